// File: rtl/conv_pkg.sv
// Shared types and saturation helper for the streaming convolution engine.
package conv_pkg;

  // Default sample width and the matching saturation bounds.
  localparam int unsigned T_DEF = 16;
  localparam logic signed [T_DEF-1:0] SAT_MAX = {1'b0, {(T_DEF-1){1'b1}}};
  localparam logic signed [T_DEF-1:0] SAT_MIN = {1'b1, {(T_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Clamp a sign-extended value to the signed range of 'width' bits.
  // Callers sign-extend their 2T-bit or (T+1)-bit results into 64 bits first
  // and keep the low 'width' bits of the result.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v,
                                             input int unsigned width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      sat = hi;
    end else if (v < lo) begin
      sat = lo;
    end else begin
      sat = v;
    end
  endfunction

endpackage

// File: rtl/conv_mem.sv
// Simple dual-address RAM: one write port, one registered (synchronous) read port.
module conv_mem #(
  parameter int unsigned W  = 16,
  parameter int unsigned D  = 16,
  parameter int unsigned AW = (D > 1) ? $clog2(D) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  // Storage array write; contents are not reset, a new job simply overwrites them.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read so data appears one cycle after the address.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= {W{1'b0}};
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_sat_mac.sv
// Two-stage multiply / saturating-accumulate pipeline. Knows nothing about
// addressing: 'en' marks a valid operand pair, 'clr' zeroes the accumulator.
module conv_sat_mac
  import conv_pkg::*;
#(
  parameter int unsigned T = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  input  logic signed [T-1:0] a,
  input  logic signed [T-1:0] b,
  output logic signed [T-1:0] acc
);

  logic signed [T-1:0]   prod_q;
  logic signed [T-1:0]   prod_d;
  logic                  pv_q;
  logic signed [T-1:0]   acc_q;
  logic signed [T-1:0]   acc_d;
  logic signed [2*T-1:0] a_w;
  logic signed [2*T-1:0] b_w;
  logic signed [2*T-1:0] prod_full;
  logic signed [63:0]    prod_w;
  logic signed [63:0]    sum_w;

  // Full-precision product and saturated sum; neither step may wrap.
  always_comb begin
    a_w       = (2*T)'(a);
    b_w       = (2*T)'(b);
    prod_full = a_w * b_w;
    prod_w    = 64'(prod_full);
    prod_d    = T'(sat(prod_w, T));
    sum_w     = 64'(acc_q) + 64'(prod_q);
    acc_d     = T'(sat(sum_w, T));
  end

  // Product register, its valid flag, and the accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_q <= {T{1'b0}};
      pv_q   <= 1'b0;
      acc_q  <= {T{1'b0}};
    end else begin
      prod_q <= prod_d;
      pv_q   <= en;
      if (clr) begin
        acc_q <= {T{1'b0}};
      end else if (pv_q) begin
        acc_q <= acc_d;
      end else begin
        acc_q <= acc_q;
      end
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/conv_stream_param.sv
// Streaming 1-D convolution: loads N x samples and M coefficients per job,
// then emits N-M+1 saturated (optionally ReLU-clamped) outputs one at a time.
module conv_stream_param
  import conv_pkg::*;
#(
  parameter int unsigned T    = 16,
  parameter int unsigned N    = 16,
  parameter int unsigned M    = 4,
  parameter bit          RELU = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] s_data_in_x,
  input  logic         s_valid_x,
  output logic         s_ready_x,
  input  logic [T-1:0] s_data_in_f,
  input  logic         s_valid_f,
  output logic         s_ready_f,
  output logic [T-1:0] m_data_out_y,
  output logic         m_valid_y,
  input  logic         m_ready_y
);

  localparam int unsigned XCW = $clog2(N + 1);
  localparam int unsigned XAW = $clog2(N);
  localparam int unsigned FCW = $clog2(M + 1);
  localparam int unsigned FAW = $clog2(M);
  localparam int unsigned CW  = $clog2(M + 3);

  state_t          state_q, state_d;
  logic [XCW-1:0]  x_cnt_q, x_cnt_d;
  logic [FCW-1:0]  f_cnt_q, f_cnt_d;
  logic [XCW-1:0]  j_q, j_d;
  logic [CW-1:0]   c_q, c_d;
  logic            run_q;
  logic            rd_v_q;
  logic [T-1:0]    y_q, y_d;
  logic            y_valid_q, y_valid_d;

  logic            x_full;
  logic            f_full;
  logic            x_we;
  logic            f_we;
  logic            issue;
  logic            mac_clr;
  logic [XAW-1:0]  x_raddr;
  logic [FAW-1:0]  f_raddr;
  logic [T-1:0]    x_rdata;
  logic [T-1:0]    f_rdata;
  logic signed [T-1:0] acc_s;
  logic [T-1:0]    y_fin;

  // Handshake, read-address and output-shaping logic; readies depend only on
  // state and counters, and stay low until the first clock after reset.
  always_comb begin
    x_full    = (x_cnt_q == XCW'(N));
    f_full    = (f_cnt_q == FCW'(M));
    s_ready_x = run_q && (state_q == LOAD) && !x_full;
    s_ready_f = run_q && (state_q == LOAD) && !f_full;
    x_we      = s_valid_x && s_ready_x;
    f_we      = s_valid_f && s_ready_f;
    issue     = (state_q == COMPUTE) && (c_q < CW'(M));
    mac_clr   = (state_q == COMPUTE) && (c_q == {CW{1'b0}});
    if (issue) begin
      x_raddr = XAW'(j_q) + XAW'(c_q);
      f_raddr = FAW'(c_q);
    end else begin
      x_raddr = {XAW{1'b0}};
      f_raddr = {FAW{1'b0}};
    end
    if (RELU && acc_s[T-1]) begin
      y_fin = {T{1'b0}};
    end else begin
      y_fin = acc_s;
    end
  end

  // Next-state logic for the LOAD -> COMPUTE -> OUTPUT sequence and its counters.
  always_comb begin
    state_d   = state_q;
    x_cnt_d   = x_cnt_q;
    f_cnt_d   = f_cnt_q;
    j_d       = j_q;
    c_d       = c_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    case (state_q)
      LOAD: begin
        if (x_we) begin
          x_cnt_d = x_cnt_q + XCW'(1);
        end else begin
          x_cnt_d = x_cnt_q;
        end
        if (f_we) begin
          f_cnt_d = f_cnt_q + FCW'(1);
        end else begin
          f_cnt_d = f_cnt_q;
        end
        if (x_full && f_full) begin
          state_d = COMPUTE;
          c_d     = {CW{1'b0}};
          j_d     = {XCW{1'b0}};
        end else begin
          state_d = LOAD;
        end
      end
      COMPUTE: begin
        // acc holds the finished sum during the last compute cycle.
        if (c_q == CW'(M + 2)) begin
          state_d   = OUTPUT;
          y_d       = y_fin;
          y_valid_d = 1'b1;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      OUTPUT: begin
        if (m_ready_y) begin
          y_valid_d = 1'b0;
          c_d       = {CW{1'b0}};
          if (j_q == XCW'(N - M)) begin
            state_d = LOAD;
            x_cnt_d = {XCW{1'b0}};
            f_cnt_d = {FCW{1'b0}};
            j_d     = {XCW{1'b0}};
          end else begin
            state_d = COMPUTE;
            j_d     = j_q + XCW'(1);
          end
        end else begin
          state_d = OUTPUT;
        end
      end
      default: begin
        state_d   = LOAD;
        x_cnt_d   = {XCW{1'b0}};
        f_cnt_d   = {FCW{1'b0}};
        j_d       = {XCW{1'b0}};
        c_d       = {CW{1'b0}};
        y_valid_d = 1'b0;
      end
    endcase
  end

  // State, counters, read-valid pipeline flag and the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      x_cnt_q   <= {XCW{1'b0}};
      f_cnt_q   <= {FCW{1'b0}};
      j_q       <= {XCW{1'b0}};
      c_q       <= {CW{1'b0}};
      run_q     <= 1'b0;
      rd_v_q    <= 1'b0;
      y_q       <= {T{1'b0}};
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_cnt_q   <= x_cnt_d;
      f_cnt_q   <= f_cnt_d;
      j_q       <= j_d;
      c_q       <= c_d;
      run_q     <= 1'b1;
      rd_v_q    <= issue;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  conv_mem #(.W(T), .D(N), .AW(XAW)) u_xmem (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (x_we),
    .waddr_i (XAW'(x_cnt_q)),
    .wdata_i (s_data_in_x),
    .raddr_i (x_raddr),
    .rdata_o (x_rdata)
  );

  conv_mem #(.W(T), .D(M), .AW(FAW)) u_fmem (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (f_we),
    .waddr_i (FAW'(f_cnt_q)),
    .wdata_i (s_data_in_f),
    .raddr_i (f_raddr),
    .rdata_o (f_rdata)
  );

  conv_sat_mac #(.T(T)) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (rd_v_q),
    .a     (x_rdata),
    .b     (f_rdata),
    .acc   (acc_s)
  );

  assign m_data_out_y = y_q;
  assign m_valid_y    = y_valid_q;

endmodule

// File: tb/tb_conv_stream_param.sv
// Directed bench for conv_stream_param: one ReLU instance and one linear
// instance share all inputs, so both output flavours are checked per job.
module tb_conv_stream_param;

  logic clk = 1'b0;
  logic reset;
  logic signed [15:0] s_data_in_x;
  logic signed [15:0] s_data_in_f;
  logic s_valid_x, s_valid_f, m_ready_y;
  logic s_ready_x1, s_ready_f1, m_valid_y1;
  logic s_ready_x0, s_ready_f0, m_valid_y0;
  logic signed [15:0] y1, y0;

  int total = 0;
  int bad   = 0;
  int cyc_g = 0;

  logic signed [15:0] xv [32];
  logic signed [15:0] fv [8];
  logic signed [15:0] got1 [26];
  logic signed [15:0] got0 [26];
  int hs_cyc [26];
  int n_got, rdy_viol, stall_viol, first_rdy_x2, first_rdy_f2;

  conv_stream_param #(.T(16), .N(16), .M(4), .RELU(1'b1)) u_relu (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x1),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f1),
    .m_data_out_y(y1), .m_valid_y(m_valid_y1), .m_ready_y(m_ready_y)
  );

  conv_stream_param #(.T(16), .N(16), .M(4), .RELU(1'b0)) u_lin (
    .clk(clk), .reset(reset),
    .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x0),
    .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f0),
    .m_data_out_y(y0), .m_valid_y(m_valid_y0), .m_ready_y(m_ready_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  // Stream njobs jobs from xv/fv, collect outputs; everything happens at negedge.
  task automatic run_jobs(input int njobs, input bit gaps, input bit rr,
                          input int stop_after, input int budget);
    int xi, fi, n, jd;
    bit px, pf, holding;
    logic signed [15:0] held1, held0;
    xi = 0; fi = 0; n = 0; px = 1'b0; pf = 1'b0; holding = 1'b0;
    held1 = 16'sd0; held0 = 16'sd0;
    rdy_viol = 0; stall_viol = 0; first_rdy_x2 = -1; first_rdy_f2 = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (px) xi++;
      if (pf) fi++;
      if (holding) begin
        if (!m_valid_y1 || !m_valid_y0 || y1 !== held1 || y0 !== held0) stall_viol++;
      end
      jd = n / 13;
      if (xi >= 16 * (jd + 1) && fi >= 4 * (jd + 1) && (s_ready_x1 || s_ready_f1)) rdy_viol++;
      if (s_ready_x1 !== s_ready_x0 || s_ready_f1 !== s_ready_f0) rdy_viol++;
      if (first_rdy_x2 < 0 && xi >= 16 && s_ready_x1) first_rdy_x2 = cyc_g;
      if (first_rdy_f2 < 0 && fi >= 4 && s_ready_f1) first_rdy_f2 = cyc_g;
      if (xi < 16 * njobs && (!gaps || $urandom_range(0, 1) == 32'd1)) begin
        s_valid_x = 1'b1; s_data_in_x = xv[xi];
      end else begin
        s_valid_x = 1'b0; s_data_in_x = 16'sh5a5a;
      end
      if (fi < 4 * njobs && (!gaps || $urandom_range(0, 1) == 32'd1)) begin
        s_valid_f = 1'b1; s_data_in_f = fv[fi];
      end else begin
        s_valid_f = 1'b0; s_data_in_f = 16'sh2c2c;
      end
      m_ready_y = rr ? ($urandom_range(0, 1) == 32'd1) : 1'b1;
      px = s_valid_x && s_ready_x1;
      pf = s_valid_f && s_ready_f1;
      if (m_valid_y1 && m_ready_y) begin
        got1[n] = y1; got0[n] = y0; hs_cyc[n] = cyc_g;
        n++;
        holding = 1'b0;
      end else if (m_valid_y1) begin
        holding = 1'b1; held1 = y1; held0 = y0;
      end else begin
        holding = 1'b0;
      end
      if (n == stop_after) break;
    end
    n_got = n;
    @(negedge clk);
    s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; s_valid_x = 1'b0; s_valid_f = 1'b0; m_ready_y = 1'b0;
    s_data_in_x = 16'sd0; s_data_in_f = 16'sd0;
    repeat (3) @(negedge clk);
    total++; if (m_valid_y1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", m_valid_y1); end
    total++; if (y1 !== 16'sd0) begin bad++; $display("FAIL reset_data got=%0d exp=0", y1); end
    total++; if (s_ready_x1 !== 1'b0 || s_ready_f1 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", s_ready_x1, s_ready_f1); end
    reset = 1'b0;
    #1;
    total++; if (s_ready_x1 !== 1'b0) begin bad++; $display("FAIL ready_before_edge got=%b exp=0", s_ready_x1); end
    @(negedge clk);
    total++; if (s_ready_x1 !== 1'b1 || s_ready_f1 !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b%b exp=11", s_ready_x1, s_ready_f1); end
  endtask

  task automatic load_ramp;
    for (int i = 0; i < 16; i++) xv[i] = 16'(i + 1);
    for (int i = 0; i < 4; i++) fv[i] = 16'(i + 1);
  endtask

  task automatic test_basic;
    logic signed [15:0] e;
    load_ramp();
    run_jobs(1, 1'b0, 1'b0, 13, 2000);
    total++; if (n_got != 13) begin bad++; $display("FAIL basic_count got=%0d exp=13", n_got); end
    for (int j = 0; j < 13; j++) begin
      e = 16'(30 + 10 * j);
      total++; if (got1[j] !== e) begin bad++; $display("FAIL basic_relu[%0d] got=%0d exp=%0d", j, got1[j], e); end
      total++; if (got0[j] !== e) begin bad++; $display("FAIL basic_lin[%0d] got=%0d exp=%0d", j, got0[j], e); end
    end
    for (int j = 0; j < 12; j++) begin
      total++; if (hs_cyc[j + 1] - hs_cyc[j] != 8) begin bad++; $display("FAIL basic_spacing[%0d] got=%0d exp=8", j, hs_cyc[j + 1] - hs_cyc[j]); end
    end
    total++; if (rdy_viol != 0) begin bad++; $display("FAIL basic_ready got=%0d exp=0", rdy_viol); end
  endtask

  task automatic test_stall;
    logic signed [15:0] e;
    load_ramp();
    run_jobs(1, 1'b1, 1'b1, 13, 4000);
    total++; if (n_got != 13) begin bad++; $display("FAIL stall_count got=%0d exp=13", n_got); end
    for (int j = 0; j < 13; j++) begin
      e = 16'(30 + 10 * j);
      total++; if (got1[j] !== e) begin bad++; $display("FAIL stall_y[%0d] got=%0d exp=%0d", j, got1[j], e); end
    end
    total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", stall_viol); end
    total++; if (rdy_viol != 0) begin bad++; $display("FAIL stall_ready got=%0d exp=0", rdy_viol); end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 16; i++) xv[i] = 16'sd32767;
    for (int i = 0; i < 4; i++) fv[i] = 16'sd32767;
    run_jobs(1, 1'b0, 1'b0, 13, 2000);
    total++; if (n_got != 13) begin bad++; $display("FAIL satp_count got=%0d exp=13", n_got); end
    for (int j = 0; j < 13; j++) begin
      total++; if (got1[j] !== 16'sd32767 || got0[j] !== 16'sd32767) begin bad++; $display("FAIL satp_y[%0d] got=%0d/%0d exp=32767", j, got1[j], got0[j]); end
    end
    for (int i = 0; i < 4; i++) fv[i] = 16'sh8000;
    run_jobs(1, 1'b0, 1'b0, 13, 2000);
    total++; if (n_got != 13) begin bad++; $display("FAIL satn_count got=%0d exp=13", n_got); end
    for (int j = 0; j < 13; j++) begin
      total++; if (got0[j] !== 16'sh8000) begin bad++; $display("FAIL satn_lin[%0d] got=%0d exp=-32768", j, got0[j]); end
      total++; if (got1[j] !== 16'sd0) begin bad++; $display("FAIL satn_relu[%0d] got=%0d exp=0", j, got1[j]); end
    end
  endtask

  task automatic test_negative;
    logic signed [15:0] e;
    load_ramp();
    for (int i = 0; i < 4; i++) fv[i] = -16'sd1;
    run_jobs(1, 1'b0, 1'b0, 13, 2000);
    total++; if (n_got != 13) begin bad++; $display("FAIL neg_count got=%0d exp=13", n_got); end
    for (int j = 0; j < 13; j++) begin
      e = 16'(-(4 * j + 10));
      total++; if (got1[j] !== 16'sd0) begin bad++; $display("FAIL neg_relu[%0d] got=%0d exp=0", j, got1[j]); end
      total++; if (got0[j] !== e) begin bad++; $display("FAIL neg_lin[%0d] got=%0d exp=%0d", j, got0[j], e); end
    end
  endtask

  task automatic test_reset_midjob;
    logic signed [15:0] e;
    bit seen;
    load_ramp();
    run_jobs(1, 1'b0, 1'b0, 7, 2000);
    total++; if (n_got != 7 || got1[6] !== 16'sd90) begin bad++; $display("FAIL mid_partial got=%0d/%0d exp=7/90", n_got, got1[6]); end
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      seen = m_valid_y1;
    end
    total++; if (!seen) begin bad++; $display("FAIL mid_pending got=0 exp=1"); end
    #2 reset = 1'b1;
    #1;
    total++; if (m_valid_y1 !== 1'b0 || y1 !== 16'sd0) begin bad++; $display("FAIL mid_reset_out got=%b/%0d exp=0/0", m_valid_y1, y1); end
    total++; if (s_ready_x1 !== 1'b0 || s_ready_f1 !== 1'b0) begin bad++; $display("FAIL mid_reset_ready got=%b%b exp=00", s_ready_x1, s_ready_f1); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) xv[i] = 16'(16 - i);
    fv[0] = 16'sd1; fv[1] = 16'sd0; fv[2] = 16'sd0; fv[3] = 16'sd0;
    run_jobs(1, 1'b0, 1'b0, 13, 2000);
    total++; if (n_got != 13) begin bad++; $display("FAIL mid_job2_count got=%0d exp=13", n_got); end
    for (int j = 0; j < 13; j++) begin
      e = 16'(16 - j);
      total++; if (got1[j] !== e || got0[j] !== e) begin bad++; $display("FAIL mid_job2_y[%0d] got=%0d/%0d exp=%0d", j, got1[j], got0[j], e); end
    end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] e;
    load_ramp();
    for (int i = 0; i < 16; i++) xv[16 + i] = 16'(16 - i);
    fv[4] = 16'sd1; fv[5] = 16'sd0; fv[6] = 16'sd0; fv[7] = 16'sd0;
    run_jobs(2, 1'b0, 1'b0, 26, 4000);
    total++; if (n_got != 26) begin bad++; $display("FAIL b2b_count got=%0d exp=26", n_got); end
    for (int j = 0; j < 13; j++) begin
      e = 16'(30 + 10 * j);
      total++; if (got1[j] !== e) begin bad++; $display("FAIL b2b_job1[%0d] got=%0d exp=%0d", j, got1[j], e); end
      e = 16'(16 - j);
      total++; if (got0[13 + j] !== e) begin bad++; $display("FAIL b2b_job2[%0d] got=%0d exp=%0d", j, got0[13 + j], e); end
    end
    total++; if (first_rdy_x2 != hs_cyc[12] + 1) begin bad++; $display("FAIL b2b_ready_x got=%0d exp=%0d", first_rdy_x2, hs_cyc[12] + 1); end
    total++; if (first_rdy_f2 != hs_cyc[12] + 1) begin bad++; $display("FAIL b2b_ready_f got=%0d exp=%0d", first_rdy_f2, hs_cyc[12] + 1); end
    total++; if (rdy_viol != 0) begin bad++; $display("FAIL b2b_ready_idle got=%0d exp=0", rdy_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_saturate();
    test_negative();
    test_reset_midjob();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
